// File: rtl/div_16bit_pkg.sv
// Shared encodings and constants for the sequential 16-bit restoring divider.
package div_16bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_e;

    localparam int          DIV_ITERS     = 16;
    localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a second lookahead level.
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  bg;
    logic [3:0]  bp;
    logic [4:0]  bc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        bg = '0;
        bp = '0;
        bc = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            bp[k] = &p[4*k +: 4];
            bg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        // Group carries expanded fully so no carry depends on another group carry.
        bc[0] = cin;
        bc[1] = bg[0] | (bp[0] & cin);
        bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
        bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
              | (bp[2] & bp[1] & bp[0] & cin);
        bc[4] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
              | (bp[3] & bp[2] & bp[1] & bg[0]) | (bp[3] & bp[2] & bp[1] & bp[0] & cin);
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
    end

    assign sum  = p ^ c;
    assign cout = bc[4];

endmodule

// File: rtl/div_16bit.sv
// Sequential unsigned 16/16 restoring divider, one quotient bit per cycle, with start/busy/done handshake.
module div_16bit
    import div_16bit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    div_state_e  state_q;
    logic [15:0] q_shift_q;
    logic [15:0] d_reg_q;
    logic [15:0] p_rem_q;
    logic [3:0]  cnt_q;
    logic        zpend_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] quotient_q;
    logic [15:0] remainder_q;
    logic        dbz_q;

    logic [15:0] shifted;
    logic [15:0] trial;
    logic        cout;
    logic        ok;
    logic [15:0] p_rem_d;
    logic [15:0] q_shift_d;

    // Low 16 bits of the 17-bit shifted partial remainder; bit 16 is p_rem_q[15].
    assign shifted = {p_rem_q[14:0], q_shift_q[15]};

    cla_16bit u_sub (
        .a    (shifted),
        .b    (~d_reg_q),
        .cin  (1'b1),
        .sum  (trial),
        .cout (cout)
    );

    assign ok        = cout | p_rem_q[15];
    assign p_rem_d   = ok ? trial : shifted;
    assign q_shift_d = {q_shift_q[14:0], ok};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_shift_q   <= '0;
            d_reg_q     <= '0;
            p_rem_q     <= '0;
            cnt_q       <= '0;
            zpend_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        q_shift_q <= dividend;
                        d_reg_q   <= divisor;
                        p_rem_q   <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        if (divisor == 16'd0) begin
                            zpend_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    p_rem_q   <= p_rem_d;
                    q_shift_q <= q_shift_d;
                    cnt_q     <= cnt_q + 4'd1;
                    if (cnt_q == 4'(DIV_ITERS - 1)) begin
                        quotient_q  <= q_shift_d;
                        remainder_q <= p_rem_d;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // A zero-divisor accept spends one extra DONE cycle so results land one edge after accept.
                    if (zpend_q) begin
                        zpend_q     <= 1'b0;
                        quotient_q  <= DIV_ZERO_QUOT;
                        remainder_q <= q_shift_q;
                        dbz_q       <= 1'b1;
                        done_q      <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_16bit.sv
// Directed and randomized checks of div_16bit results, handshake timing, busy-ignore and reset abort.
module tb_div_16bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int total;
    int bad;

    div_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: accept one operation and return edges from accept to the first done sample (bounded).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int n);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, div_by_zero});
        end
        total++;
        if ({quotient, remainder} !== 32'h0) begin
            bad++; $display("FAIL reset_results got=%h want=00000000", {quotient, remainder});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int n;
        do_op(16'd100, 16'd7, n);
        total++;
        if (n !== 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", n); end
        total++;
        if (quotient !== 16'd14) begin bad++; $display("FAIL basic_quot got=%0d want=14", quotient); end
        total++;
        if (remainder !== 16'd2) begin bad++; $display("FAIL basic_rem got=%0d want=2", remainder); end
        total++;
        if ({busy, div_by_zero} !== 2'b10) begin
            bad++; $display("FAIL basic_busy_dbz got=%b want=10", {busy, div_by_zero});
        end
        @(posedge clk);
        #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL basic_after_done got=%b want=00", {busy, done});
        end
    endtask

    task automatic test_msb_path();
        int n;
        do_op(16'hFFFF, 16'h8001, n);
        total++;
        if ({quotient, remainder} !== {16'h0001, 16'h7FFE}) begin
            bad++; $display("FAIL msb_a got=%h/%h want=0001/7ffe", quotient, remainder);
        end
        @(posedge clk);
        #1;
        do_op(16'h8000, 16'hFFFF, n);
        total++;
        if ({quotient, remainder} !== {16'h0000, 16'h8000}) begin
            bad++; $display("FAIL msb_b got=%h/%h want=0000/8000", quotient, remainder);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_div_zero();
        int n;
        do_op(16'h1234, 16'h0000, n);
        total++;
        if (n !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", n); end
        total++;
        if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'h1234, 1'b1}) begin
            bad++; $display("FAIL dz_result got=%h/%h/%b want=ffff/1234/1", quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL dz_after_done got=%b want=00", {busy, done});
        end
        do_op(16'd9, 16'd3, n);
        total++;
        if ({quotient, remainder, div_by_zero} !== {16'd3, 16'd0, 1'b0}) begin
            bad++; $display("FAIL dz_follow got=%0d/%0d/%b want=3/0/0", quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore();
        int n;
        start    = 1'b1;
        dividend = 16'd255;
        divisor  = 16'd16;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (quotient !== 16'd3) begin
            bad++; $display("FAIL ign_midrun_hold got=%0d want=3", quotient);
        end
        n = 6;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== 16) begin bad++; $display("FAIL ign_latency got=%0d want=16", n); end
        total++;
        if ({quotient, remainder, div_by_zero} !== {16'd15, 16'd15, 1'b0}) begin
            bad++; $display("FAIL ign_result got=%0d/%0d/%b want=15/15/0", quotient, remainder, div_by_zero);
        end
        start    = 1'b1;
        dividend = 16'd7;
        divisor  = 16'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if ({busy, done, quotient} !== {2'b00, 16'd15}) begin
            bad++; $display("FAIL ign_done_cycle got=%b/%0d want=00/15", {busy, done}, quotient);
        end
        do_op(16'd1000, 16'd10, n);
        total++;
        if ({n, quotient, remainder} !== {32'd16, 16'd100, 16'd0}) begin
            bad++; $display("FAIL ign_next got=%0d/%0d/%0d want=16/100/0", n, quotient, remainder);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        start    = 1'b1;
        dividend = 16'd500;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'h0) begin
            bad++; $display("FAIL rstmid_clear got=%b%b%b/%h/%h want=000/0000/0000",
                            busy, done, div_by_zero, quotient, remainder);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", seen); end
        do_op(16'd65535, 16'd255, n);
        total++;
        if ({n, quotient, remainder} !== {32'd16, 16'd257, 16'd0}) begin
            bad++; $display("FAIL rstmid_next got=%0d/%0d/%0d want=16/257/0", n, quotient, remainder);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int n;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            if (i % 50 == 0)      b = 16'd0;
            else if (i % 50 == 1) b = 16'd1;
            else if (i % 3 == 0)  b = 16'($urandom_range(1, 255));
            else                  b = 16'($urandom_range(1, 65535));
            if (b == 16'd0) begin
                eq = 16'hFFFF; er = a; ez = 1'b1;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0;
            end
            do_op(a, b, n);
            total++;
            if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
                bad++;
                $display("FAIL rand %h/%h got=%h/%h/%b want=%h/%h/%b",
                         a, b, quotient, remainder, div_by_zero, eq, er, ez);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_msb_path();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
